// File: rtl/if_pkg.sv
// if_pkg: shared state encoding, instruction field geometry and opcodes for the fetch/decode boundary.
package if_pkg;
    typedef enum logic [1:0] {FETCH, SKID, FLUSH} state_t;
    localparam int INSTR_W = 32;
    localparam int OPC_LSB = 26;
    localparam int FUNCT_W = 6;
    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2b;
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf: one-entry holding register for a fetched word and its address.
module if_skid_buf
    import if_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               unload,
    input  logic               flush,
    input  logic [INSTR_W-1:0] din,
    input  logic [31:0]        din_pc,
    output logic [INSTR_W-1:0] dout,
    output logic [31:0]        dout_pc
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout    <= NOP_INSTR;
            dout_pc <= '0;
        end else if (flush || unload) begin
            dout    <= NOP_INSTR;
            dout_pc <= '0;
        end else if (load) begin
            dout    <= din;
            dout_pc <= din_pc;
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner and IF/ID register; fetches over req/ack, parks one word in a skid
// buffer when the decoder stalls, and flushes on redirect.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    output logic [31:0]        pc_plus4,
    output logic [5:0]         opcode,
    output logic [5:0]         funct
);
    state_t             state;
    logic [31:0]        pc, addr_q, tgt, addr_inc, skid_pc;
    logic [INSTR_W-1:0] skid_data;
    logic               slot_free, skid_load, skid_unload, skid_flush;

    assign tgt         = word_align(redirect_pc);
    assign addr_inc    = addr_q + 32'd4;
    assign slot_free   = !instr_valid || !stall;
    // Request drops with reset so an in-flight access is abandoned immediately.
    assign imem_req    = rst_n && state != SKID;
    assign imem_addr   = addr_q;
    assign pc_plus4    = instr_pc + 32'd4;
    assign opcode      = instr[INSTR_W-1:OPC_LSB];
    assign funct       = instr[FUNCT_W-1:0];
    assign skid_load   = state == FETCH && !redirect && imem_ack && !slot_free;
    assign skid_unload = state == SKID && !redirect && !stall;
    assign skid_flush  = state == SKID && redirect;

    if_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (skid_load),
        .unload  (skid_unload),
        .flush   (skid_flush),
        .din     (imem_rdata),
        .din_pc  (addr_q),
        .dout    (skid_data),
        .dout_pc (skid_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            addr_q      <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                        pc          <= tgt;
                        if (imem_ack) addr_q <= tgt;
                        else          state  <= FLUSH;
                    end else if (imem_ack && slot_free) begin
                        instr       <= imem_rdata;
                        instr_pc    <= addr_q;
                        instr_valid <= 1'b1;
                        pc          <= addr_inc;
                        addr_q      <= addr_inc;
                    end else if (imem_ack) begin
                        pc    <= addr_inc;
                        state <= SKID;
                    end else if (!stall) begin
                        instr_valid <= 1'b0;
                    end
                end
                SKID: begin
                    if (redirect) begin
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                        pc          <= tgt;
                        addr_q      <= tgt;
                        state       <= FETCH;
                    end else if (!stall) begin
                        instr    <= skid_data;
                        instr_pc <= skid_pc;
                        addr_q   <= pc;
                        state    <= FETCH;
                    end
                end
                FLUSH: begin
                    // The stale request must still complete before the new target can be issued.
                    if (redirect) pc <= tgt;
                    if (imem_ack) begin
                        addr_q <= redirect ? tgt : pc;
                        state  <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the main/ALU control decoder. It owns the PC and fetches 32-bit words from instruction memory over a req/ack handshake. It holds each fetched word in an IF/ID output register, with a one-entry skid buffer behind it, and presents opcode/funct slices to the decoder. It accepts stall and branch/jump redirect from downstream.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 00

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  word-aligned fetch address
imem_ack  in  1  read data valid this cycle; completes the request
imem_rdata  in  32  instruction word, sampled only when imem_ack=1
stall  in  1  downstream cannot accept instr this cycle
redirect  in  1  branch/jump taken; flush and refetch
redirect_pc  in  32  target address; bits [1:0] ignored and treated as 00
instr_valid  out  1  instr holds a live instruction
instr  out  32  IF/ID instruction register
instr_pc  out  32  address of instr
pc_plus4  out  32  instr_pc+4, for branch target computation
opcode  out  6  instr[31:26], combinational slice to the decoder
funct  out  6  instr[5:0], combinational slice to the decoder

Behaviour:
- Reset (async, rst_n=0):
  - Registers: state=FETCH, pc=RESET_PC, addr_q=RESET_PC, instr=0, instr_pc=0, instr_valid=0, skid=0.
  - Outputs: imem_req=0 while rst_n=0, so an outstanding request is abandoned. imem_req=1 from the first cycle after release.
- Consume: instr is consumed at a clock edge with instr_valid=1 && stall=0. Define slot_free = !instr_valid || !stall.
- Handshake: while imem_req=1 && imem_ack=0, imem_addr (=addr_q) stays stable. The memory may ack the same cycle req rises (minimum latency 1 cycle from address to capture). No request is outstanding while imem_req=0.
- FSM states: FETCH, SKID, FLUSH. Redirect has priority over every other event.
- FETCH (imem_req=1, imem_addr=addr_q):
  - redirect=1: instr_valid<=0, instr<=0; pc<=redirect_pc&~3.
    - If imem_ack=1: discard the data, addr_q<=redirect target, stay FETCH.
    - Else: go FLUSH; addr_q is unchanged.
  - imem_ack=1 && slot_free: instr<=imem_rdata, instr_pc<=addr_q, instr_valid<=1; pc, addr_q<=addr_q+4; stay FETCH. This gives back-to-back issue, 1 instr/cycle sustained.
  - imem_ack=1 && !slot_free: skid<=imem_rdata, skid_pc<=addr_q; pc<=addr_q+4; go SKID.
  - imem_ack=0: hold; if the slot is consumed, instr_valid<=0.
- SKID (imem_req=0):
  - redirect=1: discard skid, instr_valid<=0, instr<=0, pc=addr_q<=redirect_pc&~3, go FETCH.
  - stall=0: instr<=skid, instr_pc<=skid_pc, instr_valid stays 1, addr_q<=pc, go FETCH.
  - stall=1: hold.
- FLUSH (imem_req=1, imem_addr=old addr_q, stable):
  - redirect=1 again: pc<=new target only.
  - imem_ack=1: discard data, addr_q<=pc, go FETCH. instr_valid stays 0 throughout.
- Arithmetic: all addresses are 32-bit; +4 wraps modulo 2^32, so 0xFFFF_FFFC -> 0x0000_0000. pc_plus4 = instr_pc+4 with the same wrap.
- Flush value: a flushed instr reads 0. The decoder sees opcode=000000, funct=000000 (NOP); downstream qualifies writes with instr_valid.
- Simultaneous events: redirect+stall -> redirect wins and the slot is flushed. redirect+ack -> ack data discarded. stall during an outstanding request -> data goes to skid, never lost. At most one word ever sits in skid.

Decomposition:
- Package if_pkg:
  - state enum {FETCH, SKID, FLUSH}
  - NOP_INSTR = 32'h0
  - OPC_LSB=26, FUNCT_W=6, INSTR_W=32
  - opcode constants (LW, SW, RTYPE, ADDI, BEQ, J), shared with the decoder
- Sub-module if_skid_buf: one-entry data+pc holding register with load/unload/flush. It is the only natural split; the PC/FSM logic stays in the top module.

Test Plan:
- Reset release, imem acks every cycle with rdata=addr: imem_addr 0,4,8; instr_valid=1 from cycle 2 with instr_pc 0,4,8, one per cycle; opcode/funct track instr bits.
- stall=1 for 3 cycles while a request to 0x8 is acked: 0x8 lands in skid, imem_req=0 during stall, instr stays 0x4. On stall=0, instr=word@0x8, then fetch resumes at 0xC with no word lost or duplicated.
- Redirect to 0x100 while request 0x10 is outstanding (ack 2 cycles later): instr_valid=0 immediately, imem_addr stays 0x10 until ack, ack data discarded, next request addr=0x100.
- Redirect to 0x203 coincident with ack: data dropped, next imem_addr=0x200, first valid instr_pc=0x200.
- RESET_PC=32'hFFFF_FFF8, continuous acks: instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_plus4 at FFFF_FFFC = 0.
- Assert rst_n=0 mid-request and mid-SKID: imem_req=0 and instr_valid=0 asynchronously. After release the first fetch is at RESET_PC.
